// File: rtl/seq_mul_if.sv
// seq_mul_if: operand/product handshake bundle for the sequential multiplier
interface seq_mul_if;
  logic in_valid;
  logic in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic out_valid;
  logic out_ready;
  logic [63:0] product;
  logic busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/seq_mul.sv
// seq_mul: 32x32 shift-and-add multiplier built on two 32-bit adders; optional SEQ_MUL_EARLY_EXIT_EN
// ends RUN once the remaining multiplier bits are all zero.
module toy_add (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] s
);
  assign s = x + y;
endmodule

module seq_mul (
  input logic clk,
  input logic rst,
  seq_mul_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [63:0] acc, mcand;
  logic [31:0] mplier, lo, hi, mcand_hi_c;
  logic [4:0] count;
  logic carry, last;
  toy_add u_lo (.x(acc[31:0]), .y(mcand[31:0]), .s(lo));
  // mcand[63:32] is at most 0x7FFFFFFF when added, so folding the carry in cannot wrap
  assign carry = lo < acc[31:0];
  assign mcand_hi_c = mcand[63:32] + {31'd0, carry};
  toy_add u_hi (.x(acc[63:32]), .y(mcand_hi_c), .s(hi));
`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign last = (count == 5'd31) || (mplier[31:1] == 31'd0);
`else
  assign last = count == 5'd31;
`endif
  always_comb begin
    next = state;
    next = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
           state == RUN  ? (last ? DONE : RUN) :
                           (bus.out_ready ? IDLE : DONE);
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    bus.busy = state != IDLE;
    bus.product = state == DONE ? acc : 64'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
    end else begin
      state <= next;
      if (state == IDLE && bus.in_valid) begin
        mcand <= {32'd0, bus.a};
        mplier <= bus.b;
        acc <= '0;
        count <= '0;
      end else if (state == RUN) begin
        if (mplier[0]) acc <= {hi, lo};
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        count <= count + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed and random checks of seq_mul against a plain a*b model with expected latency.
module tb_seq_mul;
  logic clk = 0;
  logic rst = 1;
  int n_assert = 0;
  int n_fail = 0;
  seq_mul_if bus ();
  seq_mul dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_latency(input logic [31:0] b);
    int h = 0;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return h + 2;
`else
    return 33;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_product"}, bus.product, 64'd0);
  endtask

  // Runs one transaction; after out_valid, holds out_ready low for hold cycles.
  // If next_valid is set, a further pair is presented during the hold to prove it is ignored.
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input bit next_valid);
    logic [63:0] exp = 64'(a) * 64'(b);
    int n = 0;
    check({tag, "_ready_before"}, 64'(bus.in_ready), 64'd1);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1;
    bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    bus.a = $urandom;
    bus.b = $urandom;
    while (n < 40) begin
      n++;
      if (bus.out_valid) break;
      check({tag, "_busy_run"}, 64'({bus.busy, bus.in_ready}), 64'b10);
      tick();
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_latency(b)));
    check({tag, "_product"}, bus.product, exp);
    for (int i = 0; i < hold; i++) begin
      if (next_valid) bus.in_valid = 1;
      tick();
      check({tag, "_hold_product"}, bus.product, exp);
      check({tag, "_hold_flags"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b101);
    end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    check({tag, "_after_flags"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b010);
  endtask

  initial begin
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.a = 0;
    bus.b = 0;
    tick();
    tick();
    rst = 0;
    check_idle("reset");
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    check_idle("early_out_ready");
    txn("basic", 32'd7, 32'd6, 0, 0);
    txn("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    txn("zero_b", 32'h12345678, 32'd0, 0, 0);
    txn("zero_a", 32'd0, 32'hFFFFFFFF, 0, 0);
    txn("one_b", 32'hDEADBEEF, 32'd1, 0, 0);
    txn("bp", 32'h10000, 32'h10000, 10, 1);
    txn("bp_next", 32'd3, 32'd5, 0, 0);
    bus.a = 32'hCAFEF00D;
    bus.b = 32'hFFFFFFFF;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    check_idle("mid_reset");
    txn("post_reset", 32'h80000001, 32'h80000001, 2, 0);
    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra = $urandom;
      logic [31:0] rb = $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(31, 0);
      txn("random", ra, rb, $urandom_range(2, 0), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
